// File: rtl/dcnn_rle_pkg.sv
// Shared types and helpers for the row run-length encoder.
// Word layout: [15] pixel value, [14:9] zero, [8:0] run length.
package dcnn_rle_pkg;
   localparam int ROW_W   = 480;
   localparam int WORD_W  = 16;
   localparam int LEN_W   = 9;
   localparam int VAL_BIT = 15;
   localparam int LEN_MSB = 8;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   function automatic logic [WORD_W-1:0] mk_word(
      input logic             val,
      input logic [LEN_W-1:0] len
   );
      logic [WORD_W-1:0] w;
      w = '0;
      w[VAL_BIT] = val;
      w[LEN_MSB:0] = len;
      return w;
   endfunction
endpackage

// File: rtl/rle_out_reg.sv
// Single-entry valid/ready holding register for run words.
// Also marks the cycle a row's first word first appears.
module rle_out_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_word,
   input  logic         push_first,
   input  logic         flush,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic         data_valid,
   output logic         first_strobe,
   output logic         slot_free
);
   // A new word may enter if the slot is empty or drains this cycle.
   assign slot_free = !data_valid || ready;

   // Hold the word until accepted; flush drops it unconditionally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data         <= '0;
         data_valid   <= 1'b0;
         first_strobe <= 1'b0;
      end else begin
         first_strobe <= 1'b0;
         if (flush) begin
            data_valid <= 1'b0;
         end else if (push) begin
            data         <= push_word;
            data_valid   <= 1'b1;
            first_strobe <= push_first;
         end else if (ready) begin
            data_valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/rle_row_encoder.sv
// Run-length encodes one binary row, MSB first, into 16-bit words.
// One pixel per cycle; emits stall only while the output slot is full.
module rle_row_encoder #(
   parameter int ROW_W  = dcnn_rle_pkg::ROW_W,
   parameter int WORD_W = dcnn_rle_pkg::WORD_W,
   parameter int LEN_W  = dcnn_rle_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROW_W-1:0]  row,
   input  logic              load,
   input  logic              stop,
   input  logic              ready,
   output logic [WORD_W-1:0] data,
   output logic              data_valid,
   output logic              startDecompression,
   output logic [15:0]       rowSize,
   output logic              busy,
   output logic              done
);
   import dcnn_rle_pkg::*;

   localparam int IDX_W = $clog2(ROW_W + 1);

   state_t             state_q, state_d;
   logic [ROW_W-1:0]   sr_q;
   logic               cur_q;
   logic [LEN_W-1:0]   len_q;
   logic [IDX_W-1:0]   idx_q;
   logic [15:0]        wcnt_q;
   logic               pix, last, slot;
   logic               push, adv, flush, done_d;

   assign pix   = sr_q[ROW_W-1];
   assign last  = (idx_q == IDX_W'(ROW_W));
   assign flush = stop && (state_q != IDLE);
   assign busy  = (state_q != IDLE);

   rle_out_reg #(.W(WORD_W)) u_out (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .push_word    (mk_word(cur_q, len_q)),
      .push_first   (wcnt_q == 16'd0),
      .flush        (flush),
      .ready        (ready),
      .data         (data),
      .data_valid   (data_valid),
      .first_strobe (startDecompression),
      .slot_free    (slot)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, emit and advance decisions.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      adv     = 1'b0;
      done_d  = 1'b0;
      unique case (1'b1)
         state_q == IDLE: begin
            if (load) state_d = SCAN;
         end
         state_q == SCAN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (last) begin
               if (slot) begin
                  push    = 1'b1;
                  state_d = DRAIN;
               end
            end else if (pix == cur_q) begin
               adv = 1'b1;
            end else if (slot) begin
               push = 1'b1;
               adv  = 1'b1;
            end
         end
         state_q == DRAIN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (data_valid && ready) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Shift register, run tracking, word count and row results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q    <= '0;
         cur_q   <= 1'b0;
         len_q   <= '0;
         idx_q   <= '0;
         wcnt_q  <= '0;
         rowSize <= '0;
         done    <= 1'b0;
      end else begin
         done <= done_d;
         if (done_d) rowSize <= wcnt_q;
         if (state_q == IDLE && load) begin
            sr_q   <= {row[ROW_W-2:0], 1'b0};
            cur_q  <= row[ROW_W-1];
            len_q  <= LEN_W'(1);
            idx_q  <= IDX_W'(1);
            wcnt_q <= '0;
         end else begin
            if (push) wcnt_q <= wcnt_q + 16'd1;
            if (adv) begin
               sr_q  <= sr_q << 1;
               idx_q <= idx_q + IDX_W'(1);
               if (pix == cur_q) begin
                  len_q <= len_q + LEN_W'(1);
               end else begin
                  cur_q <= pix;
                  len_q <= LEN_W'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_rle_row_encoder.sv
// Scoreboard bench for the row run-length encoder.
// Expected words come from a reference encoder of each loaded row.
module tb_rle_row_encoder;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [479:0]  row = '0;
   logic          load = 1'b0;
   logic          stop = 1'b0;
   logic          ready = 1'b1;
   logic [15:0]   data;
   logic          data_valid;
   logic          startDecompression;
   logic [15:0]   rowSize;
   logic          busy;
   logic          done;

   int            n_chk = 0;
   int            n_fail = 0;
   logic [15:0]   sb[$];
   int            row_id = 0;
   int            seen_id = 0;
   int            row_wi = 0;
   int            hold_cnt = 0;
   bit            pending = 0;
   logic [15:0]   held_w = '0;
   int            exp_rs = 0;

   rle_row_encoder dut (
      .clk                (clk),
      .rst                (rst),
      .row                (row),
      .load               (load),
      .stop               (stop),
      .ready              (ready),
      .data               (data),
      .data_valid         (data_valid),
      .startDecompression (startDecompression),
      .rowSize            (rowSize),
      .busy               (busy),
      .done               (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int encode(input logic [479:0] r);
      logic       c;
      logic [8:0] l;
      int         n;
      c = r[479];
      l = 9'd1;
      n = 0;
      for (int i = 478; i >= 0; i--) begin
         if (r[i] == c) begin
            l = l + 9'd1;
         end else begin
            sb.push_back({c, 6'b0, l});
            n++;
            c = r[i];
            l = 9'd1;
         end
      end
      sb.push_back({c, 6'b0, l});
      return n + 1;
   endfunction

   function automatic logic [479:0] rand_row();
      logic [479:0] r;
      for (int i = 0; i < 15; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Monitor: compare accepted words, first-word strobe and hold stability.
   always @(negedge clk) begin
      if (seen_id != row_id) begin
         seen_id = row_id;
         row_wi  = 0;
      end
      if (rst || !data_valid) begin
         pending = 0;
         if (!rst) chk("sdec_idle", startDecompression, 0);
      end else begin
         if (pending) begin
            chk("hold", data, held_w);
            chk("sdec_hold", startDecompression, 0);
         end else begin
            held_w = data;
            chk("sdec", startDecompression, row_wi == 0);
         end
         if (ready && !stop) begin
            if (sb.size() == 0) begin
               chk("extra_word", data, 0);
            end else begin
               chk("word", data, sb.pop_front());
            end
            row_wi++;
            pending = 0;
         end else begin
            if (!ready) hold_cnt++;
            pending = 1;
         end
      end
   end

   // rmode: 0 ready high, 1 ready low 10 cycles at first word, 2 random.
   task automatic run_row(input logic [479:0] r, input int rmode,
                          input int exp_first, input int exp_hold,
                          input int stop_at, input int load_at,
                          input int rst_at);
      int nw, first_lat, done_cnt, done_cyc, h0;
      nw = encode(r);
      row_id++;
      h0 = hold_cnt;
      @(negedge clk);
      row = r;
      load = 1'b1;
      ready = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      row = ~r;
      first_lat = -1;
      done_cnt = 0;
      done_cyc = -1;
      for (int cyc = 1; cyc <= 4000; cyc++) begin
         @(posedge clk);
         #1;
         if (data_valid && first_lat < 0) first_lat = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rmode == 1 && first_lat == cyc) ready = 1'b0;
         if (rmode == 1 && first_lat > 0 && cyc == first_lat + 10)
            ready = 1'b1;
         if (rmode == 2) ready = 1'($urandom_range(0, 1));
         if (cyc == load_at) begin
            row = rand_row();
            load = 1'b1;
         end
         if (load_at > 0 && cyc == load_at + 1) load = 1'b0;
         if (cyc == stop_at) stop = 1'b1;
         if (stop_at > 0 && cyc == stop_at + 1) begin
            stop = 1'b0;
            chk("stop_valid", data_valid, 0);
            chk("stop_busy", busy, 0);
            chk("stop_done", done_cnt, 0);
            chk("stop_rowsize", rowSize, exp_rs);
            sb.delete();
            return;
         end
         if (cyc == rst_at) begin
            chk("pre_rst_valid", data_valid, 1);
            rst = 1'b1;
            #1;
            chk("arst_data", data, 0);
            chk("arst_valid", data_valid, 0);
            chk("arst_sdec", startDecompression, 0);
            chk("arst_rowsize", rowSize, 0);
            chk("arst_busy", busy, 0);
            chk("arst_done", done, 0);
            #2;
            rst = 1'b0;
            exp_rs = 0;
            sb.delete();
            return;
         end
         if (done_cnt > 0 && cyc >= done_cyc + 3) break;
      end
      ready = 1'b1;
      chk("done_count", done_cnt, 1);
      if (rmode == 0) chk("done_cycle", done_cyc, 481);
      if (exp_first >= 0) chk("first_latency", first_lat, exp_first);
      if (exp_hold >= 0) chk("hold_cycles", hold_cnt - h0, exp_hold);
      chk("rowsize", rowSize, nw);
      chk("left_words", sb.size(), 0);
      chk("busy_end", busy, 0);
      exp_rs = nw;
   endtask

   logic [479:0] r_alt, r_one;

   initial begin
      r_alt = {240{2'b10}};
      r_one = {1'b1, 479'b0};
      #3;
      chk("rst_data", data, 0);
      chk("rst_valid", data_valid, 0);
      chk("rst_sdec", startDecompression, 0);
      chk("rst_rowsize", rowSize, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      stop = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      chk("stop_idle_busy", busy, 0);
      stop = 1'b0;
      run_row(r_alt, 0, 1, 0, -1, -1, -1);
      run_row(r_one, 1, 1, 10, -1, -1, -1);
      run_row('0, 0, 480, 0, -1, -1, -1);
      run_row(rand_row(), 0, -1, 0, 99, -1, -1);
      run_row(rand_row(), 0, -1, 0, -1, -1, -1);
      run_row(rand_row(), 0, -1, 0, -1, 200, -1);
      run_row(r_alt, 2, -1, -1, -1, -1, -1);
      run_row(r_alt, 0, -1, -1, -1, -1, 50);
      run_row('1, 0, 480, 0, -1, -1, -1);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rle_row_encoder.md
# rle_row_encoder

Run-length encoder that turns one 480-bit binary image row into a stream of 16-bit run words for the chip's decompression path. It sits on the CPU side of the 16-bit `data` bus and is the producing end for the decompressor.
- Output: the run words, a `startDecompression` strobe on the first word of each row, and `rowSize`, the word count for the finished row.

## Interface
Parameters:
- ROW_W, 480, pixels per row.
- WORD_W, 16, output word width.
- LEN_W, 9, run-length field width (holds 1..480).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- row  in  ROW_W  raw row; sampled only on the accepted `load` edge.
- load  in  1  start encoding `row`; accepted only in IDLE.
- stop  in  1  abort current row.
- ready  in  1  consumer accepts `data` this cycle.
- data  out  WORD_W  run word: [15] pixel value, [14:9] zero, [8:0] run length.
- data_valid  out  1  `data` holds a word.
- startDecompression  out  1  one-cycle pulse with the first word of a row.
- rowSize  out  16  words emitted for the last completed row.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when the row's last word is accepted.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE, `load`=1:
  - capture `row` into a shift register;
  - set cur=row[479], len=1, idx=1, wordCnt=0;
  - go to SCAN.
- Scan order is MSB first: row[479] down to row[0].
- SCAN, one pixel per cycle: look at pixel p = row[479-idx].
  - If idx<480 and p==cur: len+=1, idx+=1.
  - If idx<480 and p≠cur: emit {cur,6'b0,len}, then cur=p, len=1, idx+=1.
  - If idx==480: emit the final run and go to DRAIN.
- An emit needs a free slot: `data_valid`=0, or `ready`=1 in the same cycle. Without a free slot, SCAN stalls with idx, len and cur held.
- Each emit increments wordCnt.
- DRAIN: when the final word is accepted (`data_valid`&`ready`):
  - `rowSize`<=wordCnt;
  - pulse `done`;
  - return to IDLE.
- `startDecompression` is high in the cycle the row's first word first becomes valid.
- `stop`=1 in SCAN or DRAIN, in any cycle:
  - clear `data_valid`, return to IDLE;
  - no `done`, `rowSize` unchanged.
  - `stop` outranks `ready` and emit in the same cycle.
- `stop` in IDLE is ignored.
- `load` outside IDLE is ignored.
- `load` and `stop` together in IDLE: `load` wins.
- Run length never exceeds 480, so there is no overflow. Words range from 0x0001–0x01E0 (value 0) to 0x8001–0x81E0 (value 1).

## Timing
- Reset values: state IDLE; `data`=0, `data_valid`=0, `startDecompression`=0, `rowSize`=0, `busy`=0, `done`=0.
- `data`/`data_valid` are registered.
- A word is presented on the edge after its emit decision and held until accepted. Holding means `data` stays stable while `data_valid` is high and `ready` is low.
- Uniform row with `ready`=1: the single word is valid 480 edges after the load edge, and `done` follows on the next edge.
- Minimum row time: 481 cycles from load to `done`, independent of run count.
- With `ready` held low, at most one word is buffered and the scan freezes. No word is ever dropped or duplicated.
- `ready` is ignored while `data_valid`=0.

## Structure
- Package `dcnn_rle_pkg`:
  - ROW_W, WORD_W, LEN_W;
  - state enum {IDLE,SCAN,DRAIN};
  - field constants VAL_BIT=15, LEN_MSB=8;
  - function `mk_word(val,len)`.
- Sub-module `rle_out_reg`: the single-entry valid/ready holding register. It produces the slot-free signal and the first-word strobe.
- Top: FSM, shift register, run counter, word counter.

## Test plan
- All-zero row, `ready`=1 → one word 0x01E0, valid 480 cycles after load; `rowSize`=1; `done` pulses once.
- Row {240{2'b10}}, `ready`=1 → 480 words alternating 0x8001/0x0001, one per cycle; `rowSize`=480.
- Row {1'b1, 479'b0} with `ready` low for 10 cycles once 0x8001 is valid → 0x8001 held stable for 10 cycles, then 0x01DF; `rowSize`=2.
- `stop` on the 100th SCAN cycle of a row with `rowSize`=1 from the previous row → `data_valid` drops next edge, `busy`=0, no `done`, `rowSize` stays 1. A following `load` encodes correctly.
- `rst` asserted mid-SCAN with `data_valid`=1 → all outputs at reset values immediately, asynchronously.
- `load` pulsed during SCAN → ignored; output word stream identical to the undisturbed run.
